// File: rtl/btu_pkg.sv
// Shared definitions for the branch target unit: parameter defaults,
// operation mode encodings and a small capture-qualification helper.
package btu_pkg;

  localparam int BTU_WIDTH_DEF = 32;
  localparam int BTU_IMM_W_DEF = 16;
  localparam int BTU_DEPTH_DEF = 16;

  localparam logic [1:0] MODE_BRANCH = 2'd0;
  localparam logic [1:0] MODE_JUMP   = 2'd1;
  localparam logic [1:0] MODE_JR     = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  // An operation is captured only when present and not the reserved mode.
  function automatic logic is_capture(input logic valid, input logic [1:0] mode);
    return valid && (mode != MODE_RSVD);
  endfunction

endpackage

// File: rtl/btb_store.sv
// Branch target buffer: direct-mapped storage of tag, target and valid bit.
// Index is pc[IDX_W+1:2]; the tag is every PC bit above the index. The
// lookup is registered and reads the array state from before any write on
// the same edge, so a same-index write is not visible until the next lookup.
module btb_store
  import btu_pkg::*;
#(
  parameter int WIDTH = BTU_WIDTH_DEF,
  parameter int DEPTH = BTU_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             inval_i,
  input  logic [WIDTH-1:0] wr_pc_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [WIDTH-1:0] lookup_pc_i,
  output logic             hit_o,
  output logic [WIDTH-1:0] pred_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = WIDTH - IDX_W - 2;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic             hit_q;
  logic [WIDTH-1:0] pred_q;

  logic [IDX_W-1:0] wr_idx_s;
  logic [TAG_W-1:0] wr_tag_s;
  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             wr_tag_match_s;
  logic             lk_hit_s;
  logic             unused_s;

  assign wr_idx_s = wr_pc_i[IDX_W+1:2];
  assign wr_tag_s = wr_pc_i[WIDTH-1:IDX_W+2];
  assign lk_idx_s = lookup_pc_i[IDX_W+1:2];
  assign lk_tag_s = lookup_pc_i[WIDTH-1:IDX_W+2];

  // Byte-offset bits never take part in indexing or tag compare.
  assign unused_s = ^{wr_pc_i[1:0], lookup_pc_i[1:0]};

  assign wr_tag_match_s = valid_q[wr_idx_s] && (tag_q[wr_idx_s] == wr_tag_s);
  assign lk_hit_s       = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);

  // Next valid vector: set on write, clear on a tag-matching invalidate.
  always_comb begin
    valid_d = valid_q;
    if (we_i) begin
      valid_d[wr_idx_s] = 1'b1;
    end else if (inval_i && wr_tag_match_s) begin
      valid_d[wr_idx_s] = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits and registered lookup result, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      hit_q   <= 1'b0;
      pred_q  <= '0;
    end else begin
      valid_q <= valid_d;
      hit_q   <= lk_hit_s;
      pred_q  <= lk_hit_s ? data_q[lk_idx_s] : '0;
    end
  end

  // Tag and target payload; meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_s]  <= wr_tag_s;
      data_q[wr_idx_s] <= wr_data_i;
    end
  end

  assign hit_o  = hit_q;
  assign pred_o = pred_q;

endmodule

// File: rtl/branch_target_unit.sv
// Branch target unit: computes BRANCH / JUMP / JR targets into a one-cycle
// pipeline register toward ex_mem, and maintains a small BTB that predicts
// targets for the fetch PC.
// Optional build macro: BTU_ALIGN_CHECK_EN enables the registered
// misalign_out flag (target[1:0] != 0); otherwise misalign_out is tied low.
module branch_target_unit
  import btu_pkg::*;
#(
  parameter int WIDTH = BTU_WIDTH_DEF,
  parameter int IMM_W = BTU_IMM_W_DEF,
  parameter int DEPTH = BTU_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [1:0]        mode_in,
  input  logic [WIDTH-1:0]  pc_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [WIDTH-7:0]  jidx_in,
  input  logic [WIDTH-1:0]  rs_in,
  input  logic              taken_in,
  input  logic [WIDTH-1:0]  lookup_pc_in,
  output logic              valid_out,
  output logic [WIDTH-1:0]  addr_out,
  output logic              misalign_out,
  output logic              hit_out,
  output logic [WIDTH-1:0]  pred_addr_out
);

  logic [WIDTH-1:0] imm_ext_s;
  logic [WIDTH-1:0] target_s;
  logic             capture_s;
  logic             advance_s;
  logic             btb_we_s;
  logic             btb_inval_s;

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] addr_d;

  assign imm_ext_s = {{(WIDTH-IMM_W){imm_in[IMM_W-1]}}, imm_in};
  assign capture_s = is_capture(valid_in, mode_in);
  // The register (and the BTB) only take new operations when neither
  // stalled nor flushed.
  assign advance_s = !stall && !flush;

  // Target selection by operation mode; reserved mode yields no target.
  always_comb begin
    target_s = '0;
    case (mode_in)
      MODE_BRANCH: target_s = pc_in + {imm_ext_s[WIDTH-3:0], 2'b00};
      MODE_JUMP:   target_s = {pc_in[WIDTH-1:WIDTH-4], jidx_in, 2'b00};
      MODE_JR:     target_s = rs_in;
      default:     target_s = '0;
    endcase
  end

  // Pipeline register next state: flush beats stall, stall holds.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d = capture_s;
      if (capture_s) begin
        addr_d = target_s;
      end else begin
        addr_d = addr_q;
      end
    end
  end

  // Pipeline register toward ex_mem.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_out = valid_q;
  assign addr_out  = addr_q;

`ifdef BTU_ALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_d;

  // Misalign flag follows the captured target, cleared by flush.
  always_comb begin
    misalign_d = misalign_q;
    if (flush) begin
      misalign_d = 1'b0;
    end else if (stall) begin
      misalign_d = misalign_q;
    end else if (capture_s) begin
      misalign_d = (target_s[1:0] != 2'b00);
    end else begin
      misalign_d = misalign_q;
    end
  end

  // Misalign flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_out = misalign_q;
`else
  assign misalign_out = 1'b0;
`endif

  // Taken branches and unconditional jumps train the BTB; a not-taken
  // branch evicts a matching entry. Reset discards anything in flight.
  assign btb_we_s    = !rst && advance_s && capture_s &&
                       ((mode_in != MODE_BRANCH) || taken_in);
  assign btb_inval_s = !rst && advance_s && capture_s &&
                       (mode_in == MODE_BRANCH) && !taken_in;

  btb_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_btb_store (
    .clk         (clk),
    .rst         (rst),
    .we_i        (btb_we_s),
    .inval_i     (btb_inval_s),
    .wr_pc_i     (pc_in),
    .wr_data_i   (target_s),
    .lookup_pc_i (lookup_pc_in),
    .hit_o       (hit_out),
    .pred_o      (pred_addr_out)
  );

endmodule

// File: tb/tb_branch_target_unit.sv
// Self-checking bench for branch_target_unit (WIDTH=32, IMM_W=16, DEPTH=16):
// directed spec vectors followed by randomized traffic, all compared against
// a behavioural model of the target arithmetic and BTB contents.
module tb_branch_target_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in, taken_in;
  logic [1:0]  mode_in;
  logic [31:0] pc_in, rs_in, lookup_pc_in;
  logic [15:0] imm_in;
  logic [25:0] jidx_in;
  logic        valid_out, misalign_out, hit_out;
  logic [31:0] addr_out, pred_addr_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit          m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_dat [16];
  logic        e_valid, e_mis, e_hit;
  logic [31:0] e_addr, e_pred;

  always #5 clk = ~clk;

  branch_target_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .valid_in      (valid_in),
    .mode_in       (mode_in),
    .pc_in         (pc_in),
    .imm_in        (imm_in),
    .jidx_in       (jidx_in),
    .rs_in         (rs_in),
    .taken_in      (taken_in),
    .lookup_pc_in  (lookup_pc_in),
    .valid_out     (valid_out),
    .addr_out      (addr_out),
    .misalign_out  (misalign_out),
    .hit_out       (hit_out),
    .pred_addr_out (pred_addr_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [1:0] m, input logic [31:0] pc,
                                             input logic [15:0] imm, input logic [25:0] jidx,
                                             input logic [31:0] rs);
    longint off;
    longint sum;
    off = longint'(imm);
    if (imm >= 16'h8000) off = off - 65536;
    case (m)
      2'd0: begin
        sum = longint'(pc) + off * 4;
        return sum[31:0];
      end
      2'd1: return (pc & 32'hF000_0000) | (32'(jidx) * 32'd4);
      2'd2: return rs;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    int          li, wi;
    logic [25:0] lt, wt;
    logic [31:0] t;
    logic        cap;
    li = int'((lookup_pc_in >> 2) % 16);
    lt = 26'(lookup_pc_in >> 6);
    wi = int'((pc_in >> 2) % 16);
    wt = 26'(pc_in >> 6);
    t  = ref_target(mode_in, pc_in, imm_in, jidx_in, rs_in);
    cap = valid_in && (mode_in != 2'd3);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
      e_valid = 1'b0; e_addr = 32'h0; e_mis = 1'b0; e_hit = 1'b0; e_pred = 32'h0;
    end else begin
      e_hit  = m_v[li] && (m_tag[li] == lt);
      e_pred = e_hit ? m_dat[li] : 32'h0;
      if (flush) begin
        e_valid = 1'b0;
        e_mis   = 1'b0;
      end else if (!stall) begin
        e_valid = cap;
        if (cap) begin
          e_addr = t;
`ifdef BTU_ALIGN_CHECK_EN
          e_mis = (t % 4) != 0;
`else
          e_mis = 1'b0;
`endif
        end
      end
      if (cap && !stall && !flush) begin
        if (mode_in != 2'd0 || taken_in) begin
          m_v[wi] = 1'b1; m_tag[wi] = wt; m_dat[wi] = t;
        end else if (m_v[wi] && m_tag[wi] == wt) begin
          m_v[wi] = 1'b0;
        end
      end
    end
  endtask

  // Apply current inputs across one edge, then compare every output.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("valid_out", {31'b0, valid_out}, {31'b0, e_valid});
    check("addr_out", addr_out, e_addr);
    check("misalign_out", {31'b0, misalign_out}, {31'b0, e_mis});
    check("hit_out", {31'b0, hit_out}, {31'b0, e_hit});
    check("pred_addr_out", pred_addr_out, e_pred);
  endtask

  task automatic op(input logic v, input logic [1:0] m, input logic [31:0] pc,
                    input logic [15:0] imm, input logic [25:0] jidx,
                    input logic [31:0] rs, input logic tk);
    valid_in = v; mode_in = m; pc_in = pc; imm_in = imm;
    jidx_in = jidx; rs_in = rs; taken_in = tk;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; lookup_pc_in = 32'h0;
    op(1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
    @(negedge clk);
    cyc();
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_hit", {31'b0, hit_out}, 32'd0);
    rst = 1'b0;

    op(1'b1, 2'd0, 32'h0040_0004, 16'hFFFF, 26'h0, 32'h0, 1'b1);
    cyc();
    check("br_neg_valid", {31'b0, valid_out}, 32'd1);
    check("br_neg_addr", addr_out, 32'h0040_0000);

    op(1'b1, 2'd1, 32'h1000_0004, 16'h0, 26'h010_0000, 32'h0, 1'b0);
    cyc();
    check("jump_addr", addr_out, 32'h1040_0000);

    op(1'b1, 2'd0, 32'hFFFF_FFFC, 16'h0001, 26'h0, 32'h0, 1'b0);
    cyc();
    check("br_wrap_addr", addr_out, 32'h0000_0000);

    op(1'b1, 2'd2, 32'h0, 16'h0, 26'h0, 32'h0040_0002, 1'b0);
    cyc();
    check("jr_addr", addr_out, 32'h0040_0002);
`ifdef BTU_ALIGN_CHECK_EN
    check("jr_misalign", {31'b0, misalign_out}, 32'd1);
`else
    check("jr_misalign", {31'b0, misalign_out}, 32'd0);
`endif

    // Train: taken branch at 0x00400010 -> 0x00400040.
    op(1'b1, 2'd0, 32'h0040_0010, 16'h000C, 26'h0, 32'h0, 1'b1);
    cyc();
    check("train_addr", addr_out, 32'h0040_0040);
    op(1'b1, 2'd2, 32'h0, 16'h0, 26'h0, 32'h0040_0100, 1'b0);
    lookup_pc_in = 32'h0040_0010;
    cyc();
    check("btb_hit", {31'b0, hit_out}, 32'd1);
    check("btb_pred", pred_addr_out, 32'h0040_0040);
    lookup_pc_in = 32'h0040_0050;
    cyc();
    check("btb_tag_miss", {31'b0, hit_out}, 32'd0);
    check("btb_miss_pred", pred_addr_out, 32'h0);

    // Stall three cycles with a new jump presented.
    stall = 1'b1;
    op(1'b1, 2'd1, 32'h0040_0020, 16'h0, 26'h000_1234, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_addr", addr_out, 32'h0040_0100);
      check("stall_valid", {31'b0, valid_out}, 32'd1);
    end
    flush = 1'b1;
    cyc();
    check("flush_in_stall", {31'b0, valid_out}, 32'd0);
    stall = 1'b0; flush = 1'b0;
    op(1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
    lookup_pc_in = 32'h0040_0020;
    cyc();
    check("stall_no_write", {31'b0, hit_out}, 32'd0);

    // Reset mid-sequence with a write presented.
    op(1'b1, 2'd1, 32'h0040_0030, 16'h0, 26'h000_0040, 32'h0, 1'b1);
    cyc();
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    lookup_pc_in = 32'h0040_0010;
    cyc();
    check("rst_mid_addr", addr_out, 32'h0);
    check("rst_mid_valid", {31'b0, valid_out}, 32'd0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    op(1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
    cyc();
    check("post_rst_miss_a", {31'b0, hit_out}, 32'd0);
    lookup_pc_in = 32'h0040_0030;
    cyc();
    check("post_rst_miss_b", {31'b0, hit_out}, 32'd0);

    // Randomized traffic over a narrow PC window so entries collide and hit.
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      op($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
         32'h0040_0000 + 32'($urandom_range(0, 63)) * 32'd4,
         16'($urandom), 26'($urandom), $urandom, 1'($urandom_range(0, 1)));
      lookup_pc_in = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 32'd4 +
                     32'($urandom_range(0, 3));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_target_unit.md
BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 Parameter WIDTH, default 32, address/data width in bits.
REQ-002 Parameter IMM_W, default 16, raw branch-immediate width.
REQ-003 Parameter DEPTH, default 16, branch-target-buffer entries; power of two, 2..256.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port stall  in  1  hold the pipeline register.
REQ-007 Port flush  in  1  squash the result being captured.
REQ-008 Port valid_in  in  1  operation present this cycle.
REQ-009 Port mode_in  in  2  0=BRANCH, 1=JUMP, 2=JR, 3=reserved.
REQ-010 Port pc_in  in  WIDTH  PC+4 from id_ex.
REQ-011 Port imm_in  in  IMM_W  raw branch offset, in words.
REQ-012 Port jidx_in  in  WIDTH-6  jump index field.
REQ-013 Port rs_in  in  WIDTH  register target for JR.
REQ-014 Port taken_in  in  1  branch resolved taken; ignored for JUMP/JR.
REQ-015 Port lookup_pc_in  in  WIDTH  fetch PC for BTB prediction.
REQ-016 Port valid_out  out  1  addr_out holds a valid target.
REQ-017 Port addr_out  out  WIDTH  computed target, to ex_mem.
REQ-018 Port misalign_out  out  1  addr_out[1:0] nonzero.
REQ-019 Port hit_out  out  1  BTB hit for the previous cycle's lookup_pc_in.
REQ-020 Port pred_addr_out  out  WIDTH  predicted target; zero when hit_out=0.

Function
REQ-021 BRANCH target SHALL be pc_in + (sign_extend(imm_in) << 2), modulo 2^WIDTH.
REQ-022 JUMP target SHALL be {pc_in[WIDTH-1:WIDTH-4], jidx_in, 2'b00}.
REQ-023 JR target SHALL be rs_in unchanged.
REQ-024 Mode 3 SHALL be dropped: no capture, valid_out=0 next cycle, no BTB write.
REQ-025 Latency SHALL be one cycle: with stall=0, inputs at edge N appear on the outputs after edge N.
REQ-026 stall=1 SHALL hold valid_out, addr_out and misalign_out and block BTB writes.
REQ-027 flush=1 SHALL clear valid_out next cycle and block the BTB write; flush takes priority over stall.
REQ-028 A BTB write SHALL occur on a captured valid JUMP, JR, or BRANCH with taken_in=1: index pc_in[log2(DEPTH)+1:2], stored tag = the remaining upper bits, data = target.
REQ-029 A captured BRANCH with taken_in=0 SHALL invalidate the indexed entry only on a tag match.
REQ-030 Lookup SHALL be registered: hit_out/pred_addr_out reflect lookup_pc_in at the previous edge; lookup is unaffected by stall and flush.
REQ-031 A lookup and a write to the same index on the same edge SHALL return the pre-write contents.

Reset
REQ-032 rst SHALL clear valid_out, addr_out, misalign_out, hit_out, pred_addr_out and every BTB valid bit; rst overrides stall and flush; a write in flight at reset is discarded.

Configuration
REQ-033 With BTU_ALIGN_CHECK_EN defined, misalign_out SHALL be registered with addr_out as (target[1:0]!=0) and cleared by reset and flush; without it, misalign_out SHALL be constant 0.

Structure
REQ-034 Package btu_pkg SHALL hold the mode encodings and the parameter defaults.
REQ-035 BTB storage, tags, valid bits and read-before-write logic SHALL live in the sub-module btb_store.

Verification (WIDTH=32, IMM_W=16, DEPTH=16)
REQ-036 BRANCH, pc_in=0x00400004, imm_in=0xFFFF -> next cycle valid_out=1, addr_out=0x00400000.
REQ-037 JUMP, pc_in=0x10000004, jidx_in=0x0100000 -> addr_out=0x10400000; BRANCH, pc_in=0xFFFFFFFC, imm_in=0x0001 -> addr_out=0x00000000 (wrap).
REQ-038 JR, rs_in=0x00400002 -> addr_out=0x00400002 and misalign_out=1 with macro, 0 without.
REQ-039 Taken BRANCH at pc_in=0x00400010 with target 0x00400040; next cycle lookup 0x00400010 -> hit_out=1, pred_addr_out=0x00400040; lookup 0x00400050 (same index, different tag) -> hit_out=0.
REQ-040 stall=1 for 3 cycles with new inputs -> outputs unchanged, no BTB write; flush during stall -> valid_out=0 next cycle; rst mid-sequence -> all outputs 0 and all subsequent lookups miss.
